// File: rtl/cpu_pkg.sv
// Shared opcode constants and control-bundle layout for the decode stage.
package cpu_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_ADDIU = 6'b001001;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;

  localparam logic [4:0] LINK_REG = 5'd31;

  typedef enum logic [2:0] {
    CLS_RTYPE,
    CLS_ALU_IMM,
    CLS_BRANCH,
    CLS_LOAD,
    CLS_STORE,
    CLS_JUMP,
    CLS_ILLEGAL
  } ins_class_e;

  typedef struct packed {
    logic jump;
    logic branch;
    logic mem_to_reg;
    logic sign_ext;
    logic reg_dest;
    logic mem_write;
    logic alu_src;
    logic reg_write;
    logic link;
    logic illegal;
  } ctrl_t;

  function automatic ins_class_e classify(input logic [5:0] op);
    ins_class_e cls;
    case (op)
      OP_RTYPE:                          cls = CLS_RTYPE;
      OP_ADDIU, OP_ANDI, OP_ORI, OP_SLTI: cls = CLS_ALU_IMM;
      OP_BEQ, OP_BNE:                    cls = CLS_BRANCH;
      OP_LW:                             cls = CLS_LOAD;
      OP_SW:                             cls = CLS_STORE;
      OP_J, OP_JAL:                      cls = CLS_JUMP;
      default:                           cls = CLS_ILLEGAL;
    endcase
    return cls;
  endfunction

endpackage

// File: rtl/ctrl_table.sv
// Combinational opcode-to-control table: flags, shift amount, destination
// register and which source registers the instruction actually reads.
module ctrl_table
  import cpu_pkg::*;
(
  input  logic [5:0] op,
  input  logic [4:0] rt,
  input  logic [9:0] rd_shamt,
  output ctrl_t      ctrl,
  output logic [4:0] shamt,
  output logic [4:0] wr_addr,
  output logic       reads_rs,
  output logic       reads_rt
);

  ins_class_e cls;

  assign cls = classify(op);

  always_comb begin
    ctrl     = '0;
    shamt    = 5'd0;
    wr_addr  = 5'd0;
    reads_rs = 1'b1;
    reads_rt = 1'b0;
    case (cls)
      CLS_RTYPE: begin
        ctrl.reg_dest  = 1'b1;
        ctrl.reg_write = 1'b1;
        shamt          = rd_shamt[4:0];
        wr_addr        = rd_shamt[9:5];
        reads_rt       = 1'b1;
      end
      CLS_ALU_IMM: begin
        ctrl.alu_src   = 1'b1;
        ctrl.reg_write = 1'b1;
        ctrl.sign_ext  = (op == OP_ADDIU) || (op == OP_SLTI);
        wr_addr        = rt;
      end
      CLS_BRANCH: begin
        ctrl.branch   = 1'b1;
        ctrl.sign_ext = 1'b1;
        reads_rt      = 1'b1;
      end
      CLS_LOAD: begin
        ctrl.alu_src    = 1'b1;
        ctrl.sign_ext   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        wr_addr         = rt;
      end
      CLS_STORE: begin
        ctrl.alu_src   = 1'b1;
        ctrl.sign_ext  = 1'b1;
        ctrl.mem_write = 1'b1;
        reads_rt       = 1'b1;
      end
      CLS_JUMP: begin
        ctrl.jump = 1'b1;
        reads_rs  = 1'b0;
        if (op == OP_JAL) begin
          ctrl.link      = 1'b1;
          ctrl.reg_write = 1'b1;
          wr_addr        = LINK_REG;
        end
      end
      default: begin
        ctrl.illegal = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/decode_stage.sv
// Decode pipeline stage: registers the ctrl_table bundle behind a valid/ready
// handshake and inserts a single bubble on a load-use dependency.
module decode_stage
  import cpu_pkg::*;
#(
  parameter int XLEN      = 32,
  parameter int HAZARD_EN = 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     ins_in,
  output logic            out_valid,
  input  logic            out_ready,
  output logic            jump,
  output logic            branch,
  output logic            mem_to_reg,
  output logic            sign_ext,
  output logic            reg_dest,
  output logic            mem_write,
  output logic            alu_src,
  output logic            reg_write,
  output logic            link,
  output logic            illegal,
  output logic            bubble,
  output logic [4:0]      shamt,
  output logic [4:0]      rs,
  output logic [4:0]      rt,
  output logic [4:0]      wr_addr,
  output logic [XLEN-1:0] imm
);

  ctrl_t           dec_ctrl;
  logic [4:0]      dec_shamt;
  logic [4:0]      dec_wr_addr;
  logic            dec_reads_rs;
  logic            dec_reads_rt;
  logic [4:0]      in_rs;
  logic [4:0]      in_rt;
  logic [XLEN-1:0] dec_imm;

  logic            out_valid_q, out_valid_d;
  ctrl_t           ctrl_q, ctrl_d;
  logic            bubble_q, bubble_d;
  logic [4:0]      shamt_q, shamt_d;
  logic [4:0]      rs_q, rs_d;
  logic [4:0]      rt_q, rt_d;
  logic [4:0]      wr_addr_q, wr_addr_d;
  logic [XLEN-1:0] imm_q, imm_d;

  logic            load;
  logic            hazard;

  assign in_rs = ins_in[25:21];
  assign in_rt = ins_in[20:16];

  ctrl_table u_ctrl_table (
    .op       (ins_in[31:26]),
    .rt       (in_rt),
    .rd_shamt (ins_in[15:6]),
    .ctrl     (dec_ctrl),
    .shamt    (dec_shamt),
    .wr_addr  (dec_wr_addr),
    .reads_rs (dec_reads_rs),
    .reads_rt (dec_reads_rt)
  );

  // Width-generic extension so XLEN=16 needs no zero-width replication.
  always_comb begin
    dec_imm       = {XLEN{dec_ctrl.sign_ext & ins_in[15]}};
    dec_imm[15:0] = ins_in[15:0];
  end

  // Hazard ignores in_valid so that in_ready never depends on in_valid.
  assign hazard = (HAZARD_EN != 0) && out_valid_q && ctrl_q.mem_to_reg &&
                  (wr_addr_q != 5'd0) &&
                  ((dec_reads_rs && (in_rs == wr_addr_q)) ||
                   (dec_reads_rt && (in_rt == wr_addr_q)));

  assign load     = !out_valid_q || out_ready;
  assign in_ready = !rst && load && !hazard;

  always_comb begin
    out_valid_d = out_valid_q;
    ctrl_d      = ctrl_q;
    bubble_d    = bubble_q;
    shamt_d     = shamt_q;
    rs_d        = rs_q;
    rt_d        = rt_q;
    wr_addr_d   = wr_addr_q;
    imm_d       = imm_q;
    if (load) begin
      out_valid_d = 1'b0;
      ctrl_d      = '0;
      bubble_d    = 1'b0;
      shamt_d     = 5'd0;
      rs_d        = 5'd0;
      rt_d        = 5'd0;
      wr_addr_d   = 5'd0;
      imm_d       = '0;
      if (in_valid && !hazard) begin
        out_valid_d = 1'b1;
        ctrl_d      = dec_ctrl;
        shamt_d     = dec_shamt;
        rs_d        = in_rs;
        rt_d        = in_rt;
        wr_addr_d   = dec_wr_addr;
        imm_d       = dec_imm;
      end else if (in_valid) begin
        out_valid_d = 1'b1;
        bubble_d    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid_q <= 1'b0;
      ctrl_q      <= '0;
      bubble_q    <= 1'b0;
      shamt_q     <= 5'd0;
      rs_q        <= 5'd0;
      rt_q        <= 5'd0;
      wr_addr_q   <= 5'd0;
      imm_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      ctrl_q      <= ctrl_d;
      bubble_q    <= bubble_d;
      shamt_q     <= shamt_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      wr_addr_q   <= wr_addr_d;
      imm_q       <= imm_d;
    end
  end

  assign out_valid  = out_valid_q;
  assign jump       = ctrl_q.jump;
  assign branch     = ctrl_q.branch;
  assign mem_to_reg = ctrl_q.mem_to_reg;
  assign sign_ext   = ctrl_q.sign_ext;
  assign reg_dest   = ctrl_q.reg_dest;
  assign mem_write  = ctrl_q.mem_write;
  assign alu_src    = ctrl_q.alu_src;
  assign reg_write  = ctrl_q.reg_write;
  assign link       = ctrl_q.link;
  assign illegal    = ctrl_q.illegal;
  assign bubble     = bubble_q;
  assign shamt      = shamt_q;
  assign rs         = rs_q;
  assign rt         = rt_q;
  assign wr_addr    = wr_addr_q;
  assign imm        = imm_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: one instance with load-use bubbles enabled,
// one with them disabled, driven by hand-built instruction vectors.
module tb_decode_stage;

  localparam logic [31:0] I_ADDIU_M1 = 32'h2401FFFF;
  localparam logic [31:0] I_ANDI     = 32'h3001FFFF;
  localparam logic [31:0] I_ILLEGAL  = 32'hFC000000;
  localparam logic [31:0] I_BEQ      = 32'h10220004;
  localparam logic [31:0] I_SW       = 32'hAC430008;
  localparam logic [31:0] I_SLL      = 32'h00031080;
  localparam logic [31:0] I_LW2      = 32'h8C020000;
  localparam logic [31:0] I_ADD      = 32'h00421820;
  localparam logic [31:0] I_ADDIU_R2 = 32'h24020005;
  localparam logic [31:0] I_LW0      = 32'h8C000000;
  localparam logic [31:0] I_ADD_R0   = 32'h00000820;
  localparam logic [31:0] I_JAL      = 32'h0C000010;
  localparam logic [31:0] I_ORI      = 32'h34A51234;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_valid_nh = 1'b0;
  logic [31:0] ins_in = '0;
  logic        out_ready = 1'b1;

  logic        in_ready, out_valid, jump, branch, mem_to_reg, sign_ext, reg_dest;
  logic        mem_write, alu_src, reg_write, link, illegal, bubble;
  logic [4:0]  shamt, rs, rt, wr_addr;
  logic [31:0] imm;

  logic        in_ready_nh, out_valid_nh, jump_nh, branch_nh, mem_to_reg_nh;
  logic        sign_ext_nh, reg_dest_nh, mem_write_nh, alu_src_nh, reg_write_nh;
  logic        link_nh, illegal_nh, bubble_nh;
  logic [4:0]  shamt_nh, rs_nh, rt_nh, wr_addr_nh;
  logic [31:0] imm_nh;

  int checkCount = 0;
  int errorCount = 0;

  always #5 clk = ~clk;

  decode_stage #(.XLEN(32), .HAZARD_EN(1)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .ins_in(ins_in),
    .out_valid(out_valid), .out_ready(out_ready), .jump(jump), .branch(branch),
    .mem_to_reg(mem_to_reg), .sign_ext(sign_ext), .reg_dest(reg_dest),
    .mem_write(mem_write), .alu_src(alu_src), .reg_write(reg_write), .link(link),
    .illegal(illegal), .bubble(bubble), .shamt(shamt), .rs(rs), .rt(rt),
    .wr_addr(wr_addr), .imm(imm)
  );

  decode_stage #(.XLEN(32), .HAZARD_EN(0)) dut_nh (
    .clk(clk), .rst(rst), .in_valid(in_valid_nh), .in_ready(in_ready_nh), .ins_in(ins_in),
    .out_valid(out_valid_nh), .out_ready(out_ready), .jump(jump_nh), .branch(branch_nh),
    .mem_to_reg(mem_to_reg_nh), .sign_ext(sign_ext_nh), .reg_dest(reg_dest_nh),
    .mem_write(mem_write_nh), .alu_src(alu_src_nh), .reg_write(reg_write_nh),
    .link(link_nh), .illegal(illegal_nh), .bubble(bubble_nh), .shamt(shamt_nh),
    .rs(rs_nh), .rt(rt_nh), .wr_addr(wr_addr_nh), .imm(imm_nh)
  );

  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] ins, input logic rdy);
    in_valid  = v;
    ins_in    = ins;
    out_ready = rdy;
    #1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Reset behaviour and in_ready return right after release
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    step();
    checkOutput("rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("rst in_ready", 32'(in_ready), 32'd0);
    checkOutput("rst reg_write", 32'(reg_write), 32'd0);
    checkOutput("rst imm", imm, 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("post-rst in_ready", 32'(in_ready), 32'd1);

    // Back-to-back independent instructions, out_ready=1
    applyStimulus(1'b1, I_ADDIU_M1, 1'b1);
    step();
    checkOutput("addiu out_valid", 32'(out_valid), 32'd1);
    checkOutput("addiu alu_src", 32'(alu_src), 32'd1);
    checkOutput("addiu reg_write", 32'(reg_write), 32'd1);
    checkOutput("addiu sign_ext", 32'(sign_ext), 32'd1);
    checkOutput("addiu reg_dest", 32'(reg_dest), 32'd0);
    checkOutput("addiu wr_addr", 32'(wr_addr), 32'd1);
    checkOutput("addiu imm", imm, 32'hFFFFFFFF);

    applyStimulus(1'b1, I_ANDI, 1'b1);
    step();
    checkOutput("andi imm", imm, 32'h0000FFFF);
    checkOutput("andi sign_ext", 32'(sign_ext), 32'd0);
    checkOutput("andi alu_src", 32'(alu_src), 32'd1);
    checkOutput("andi wr_addr", 32'(wr_addr), 32'd1);

    applyStimulus(1'b1, I_ILLEGAL, 1'b1);
    step();
    checkOutput("illegal flag", 32'(illegal), 32'd1);
    checkOutput("illegal reg_write", 32'(reg_write), 32'd0);
    checkOutput("illegal mem_write", 32'(mem_write), 32'd0);
    checkOutput("illegal out_valid", 32'(out_valid), 32'd1);

    applyStimulus(1'b1, I_BEQ, 1'b1);
    step();
    checkOutput("beq branch", 32'(branch), 32'd1);
    checkOutput("beq sign_ext", 32'(sign_ext), 32'd1);
    checkOutput("beq reg_write", 32'(reg_write), 32'd0);
    checkOutput("beq rs", 32'(rs), 32'd1);
    checkOutput("beq rt", 32'(rt), 32'd2);
    checkOutput("beq illegal", 32'(illegal), 32'd0);

    applyStimulus(1'b1, I_SW, 1'b1);
    step();
    checkOutput("sw mem_write", 32'(mem_write), 32'd1);
    checkOutput("sw alu_src", 32'(alu_src), 32'd1);
    checkOutput("sw reg_write", 32'(reg_write), 32'd0);
    checkOutput("sw imm", imm, 32'h00000008);

    applyStimulus(1'b1, I_SLL, 1'b1);
    step();
    checkOutput("sll shamt", 32'(shamt), 32'd2);
    checkOutput("sll wr_addr", 32'(wr_addr), 32'd2);
    checkOutput("sll reg_dest", 32'(reg_dest), 32'd1);
    checkOutput("sll alu_src", 32'(alu_src), 32'd0);

    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("idle out_valid", 32'(out_valid), 32'd0);

    // Load-use: lw $2 then add $3,$2,$2 on both instances
    in_valid_nh = 1'b1;
    applyStimulus(1'b1, I_LW2, 1'b1);
    step();
    checkOutput("lw out_valid", 32'(out_valid), 32'd1);
    checkOutput("lw mem_to_reg", 32'(mem_to_reg), 32'd1);
    checkOutput("lw wr_addr", 32'(wr_addr), 32'd2);
    checkOutput("nh lw mem_to_reg", 32'(mem_to_reg_nh), 32'd1);
    applyStimulus(1'b1, I_ADD, 1'b1);
    checkOutput("hazard in_ready", 32'(in_ready), 32'd0);
    checkOutput("nh hazard in_ready", 32'(in_ready_nh), 32'd1);
    step();
    checkOutput("bubble flag", 32'(bubble), 32'd1);
    checkOutput("bubble out_valid", 32'(out_valid), 32'd1);
    checkOutput("bubble reg_write", 32'(reg_write), 32'd0);
    checkOutput("bubble wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("bubble rs", 32'(rs), 32'd0);
    checkOutput("after bubble in_ready", 32'(in_ready), 32'd1);
    checkOutput("nh add bubble", 32'(bubble_nh), 32'd0);
    checkOutput("nh add wr_addr", 32'(wr_addr_nh), 32'd3);
    checkOutput("nh add reg_write", 32'(reg_write_nh), 32'd1);
    in_valid_nh = 1'b0;
    step();
    checkOutput("add bubble", 32'(bubble), 32'd0);
    checkOutput("add wr_addr", 32'(wr_addr), 32'd3);
    checkOutput("add reg_dest", 32'(reg_dest), 32'd1);
    checkOutput("add out_valid", 32'(out_valid), 32'd1);
    checkOutput("nh idle out_valid", 32'(out_valid_nh), 32'd0);

    // lw $2 followed by an instruction that only names $2 as rt destination
    applyStimulus(1'b1, I_LW2, 1'b1);
    step();
    applyStimulus(1'b1, I_ADDIU_R2, 1'b1);
    checkOutput("no-read-rt in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("addiu r2 bubble", 32'(bubble), 32'd0);
    checkOutput("addiu r2 wr_addr", 32'(wr_addr), 32'd2);

    // lw to $0 never stalls
    applyStimulus(1'b1, I_LW0, 1'b1);
    step();
    applyStimulus(1'b1, I_ADD_R0, 1'b1);
    checkOutput("lw r0 in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("add r0 bubble", 32'(bubble), 32'd0);
    checkOutput("add r0 wr_addr", 32'(wr_addr), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();

    // jal held under backpressure, then released
    applyStimulus(1'b1, I_JAL, 1'b0);
    step();
    applyStimulus(1'b1, I_ORI, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("jal hold%0d out_valid", i), 32'(out_valid), 32'd1);
      checkOutput($sformatf("jal hold%0d jump", i), 32'(jump), 32'd1);
      checkOutput($sformatf("jal hold%0d link", i), 32'(link), 32'd1);
      checkOutput($sformatf("jal hold%0d wr_addr", i), 32'(wr_addr), 32'd31);
      checkOutput($sformatf("jal hold%0d in_ready", i), 32'(in_ready), 32'd0);
      step();
    end
    applyStimulus(1'b1, I_ORI, 1'b1);
    checkOutput("release in_ready", 32'(in_ready), 32'd1);
    checkOutput("release jump", 32'(jump), 32'd1);
    step();
    checkOutput("ori link", 32'(link), 32'd0);
    checkOutput("ori wr_addr", 32'(wr_addr), 32'd5);
    checkOutput("ori imm", imm, 32'h00001234);
    checkOutput("ori sign_ext", 32'(sign_ext), 32'd0);
    applyStimulus(1'b0, 32'h0, 1'b1);
    step();
    checkOutput("post-ori out_valid", 32'(out_valid), 32'd0);

    // Reset while a bundle is stalled
    applyStimulus(1'b1, I_LW2, 1'b0);
    step();
    checkOutput("stall lw out_valid", 32'(out_valid), 32'd1);
    applyStimulus(1'b0, 32'h0, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("mid-rst in_ready", 32'(in_ready), 32'd0);
    step();
    checkOutput("mid-rst out_valid", 32'(out_valid), 32'd0);
    checkOutput("mid-rst mem_to_reg", 32'(mem_to_reg), 32'd0);
    checkOutput("mid-rst wr_addr", 32'(wr_addr), 32'd0);
    checkOutput("mid-rst reg_write", 32'(reg_write), 32'd0);
    checkOutput("mid-rst rt", 32'(rt), 32'd0);
    rst = 1'b0;
    #1;
    checkOutput("after mid-rst in_ready", 32'(in_ready), 32'd1);
    step();
    checkOutput("after mid-rst out_valid", 32'(out_valid), 32'd0);

    $display("Result: errors=%0d of %0d checks", errorCount, checkCount);
    $finish;
  end

endmodule
